// File: rtl/aes_key_expander_if.sv
// Key-load handshake and round-key read port of aes_key_expander.
// AES_KEYEXP_LAST_KEY_EN adds the last_key output.
interface aes_key_expander_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [127:0]      key_in;
   logic              key_valid;
   logic              key_ready;
   logic              busy;
   logic              done;
   logic              keys_valid;
   logic [ADDR_W-1:0] rk_addr;
   logic [127:0]      rk_data;
`ifdef AES_KEYEXP_LAST_KEY_EN
   logic [127:0]      last_key;

   modport master (
      output key_in, key_valid, rk_addr,
      input  key_ready, busy, done, keys_valid, rk_data, last_key
   );
   modport slave (
      input  key_in, key_valid, rk_addr,
      output key_ready, busy, done, keys_valid, rk_data, last_key
   );
`else
   modport master (
      output key_in, key_valid, rk_addr,
      input  key_ready, busy, done, keys_valid, rk_data
   );
   modport slave (
      input  key_in, key_valid, rk_addr,
      output key_ready, busy, done, keys_valid, rk_data
   );
`endif
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expansion: one round per clock, 11 round keys in a registered-read store.
// Optional feature macro: AES_KEYEXP_LAST_KEY_EN (adds the last_key register/output).
module aes_key_expander #(
   parameter int unsigned NR     = 10,
   parameter int unsigned ADDR_W = 4
) (
   input logic               clk,
   input logic               rst,
   aes_key_expander_if.slave bus
);

   typedef enum logic {StIdle, StExpand} state_e;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      c = 8'h00;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // One AES_key_schedule step: next 4-word round key from the previous one.
   function automatic logic [127:0] key_round(input logic [127:0] w, input logic [3:0] r);
      logic [31:0] t, n0, n1, n2, n3;
      t  = {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]} ^ {rcon(r), 24'h0};
      n0 = w[127:96] ^ t;
      n1 = w[95:64]  ^ n0;
      n2 = w[63:32]  ^ n1;
      n3 = w[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   state_e       state_q, state_d;
   logic [3:0]   rnd_q;
   logic [127:0] work_q;
   logic [127:0] rk_q [0:NR];
   logic [127:0] rk_data_q;
   logic         done_q;
   logic         keys_valid_q;
   logic [127:0] ks_out;
   logic         accept;
   logic         last_rnd;

   assign ks_out   = key_round(work_q, rnd_q);
   assign last_rnd = (rnd_q == 4'(NR));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.key_valid) begin
               accept  = 1'b1;
               state_d = StExpand;
            end
         end
         StExpand: begin
            if (last_rnd) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd_q        <= '0;
         work_q       <= '0;
         done_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            rk_q[0]      <= bus.key_in;
            work_q       <= bus.key_in;
            rnd_q        <= 4'd1;
            keys_valid_q <= 1'b0;
         end else if (state_q == StExpand) begin
            rk_q[rnd_q] <= ks_out;
            work_q      <= ks_out;
            if (last_rnd) begin
               done_q       <= 1'b1;
               keys_valid_q <= 1'b1;
            end else begin
               rnd_q <= rnd_q + 4'd1;
            end
         end
      end
   end

   // Registered read; a same-edge write is not visible until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                rk_data_q <= '0;
      else if (bus.rk_addr <= ADDR_W'(NR))    rk_data_q <= rk_q[bus.rk_addr];
      else                                    rk_data_q <= '0;
   end

`ifdef AES_KEYEXP_LAST_KEY_EN
   logic [127:0] last_key_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         last_key_q <= '0;
      else if (accept)                                 last_key_q <= '0;
      else if ((state_q == StExpand) && last_rnd)      last_key_q <= ks_out;
   end

   assign bus.last_key = last_key_q;
`endif

   assign bus.key_ready  = (state_q == StIdle);
   assign bus.busy       = (state_q == StExpand);
   assign bus.done       = done_q;
   assign bus.keys_valid = keys_valid_q;
   assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a FIPS-197 key-expansion model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expander;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   aes_key_expander_if #(.ADDR_W(4)) bus ();

   aes_key_expander #(.NR(10), .ADDR_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [7:0]   sbox_tab [0:255];
   logic [127:0] exp_rk   [0:10];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xtime(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic start_key(input logic [127:0] k);
      @(negedge clk);
      bus.key_in    = k;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
      @(negedge clk);
      bus.rk_addr = a;
      @(negedge clk);
      d = bus.rk_data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.key_in = '0; bus.key_valid = 1'b0; bus.rk_addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.key_ready, bus.busy, bus.done, bus.keys_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_flags got ready/busy/done/kv=%b exp 1000",
                  {bus.key_ready, bus.busy, bus.done, bus.keys_valid});
      end
      checks++;
      if (bus.rk_data !== 128'h0) begin
         failures++;
         $display("FAIL reset_rk_data got %h exp 0", bus.rk_data);
      end
   endtask

   task automatic test_expand(input string name, input logic [127:0] key);
      int cyc, extra;
      logic [127:0] d;
      model_expand(key);
      start_key(key);
      wait_done(cyc);
      checks++;
      if (cyc != 10) begin
         failures++;
         $display("FAIL %s_done_latency got %0d exp 10", name, cyc);
      end
      checks++;
      if (bus.keys_valid !== 1'b1 || bus.key_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_cycle got kv=%b ready=%b exp 1 1", name, bus.keys_valid,
                  bus.key_ready);
      end
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      checks++;
      if (extra != 0) begin
         failures++;
         $display("FAIL %s_done_pulse got %0d extra pulses exp 0", name, extra);
      end
      for (int r = 0; r <= 10; r++) begin
         read_rk(4'(r), d);
         checks++;
         if (d !== exp_rk[r]) begin
            failures++;
            $display("FAIL %s_rk%0d got %h exp %h", name, r, d, exp_rk[r]);
         end
      end
   endtask

   task automatic test_known_vectors();
      logic [127:0] d;
      test_expand("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
      read_rk(4'd1, d);
      checks++;
      if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
         failures++;
         $display("FAIL fips_rk1_vector got %h exp a0fafe1788542cb123a339392a6c7605", d);
      end
      read_rk(4'd10, d);
      checks++;
      if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
         failures++;
         $display("FAIL fips_rk10_vector got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", d);
      end
      test_expand("zero", 128'h0);
      read_rk(4'd1, d);
      checks++;
      if (d !== 128'h62636363626363636263636362636363) begin
         failures++;
         $display("FAIL zero_rk1_vector got %h exp 62636363626363636263636362636363", d);
      end
      read_rk(4'd10, d);
      checks++;
      if (d !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
         failures++;
         $display("FAIL zero_rk10_vector got %h exp b4ef5bcb3e92e21123e951cf6f8f188e", d);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3; n++)
         test_expand("rand", {$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic test_back_to_back();
      logic [127:0] ka, kb, d;
      int cyc;
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      start_key(ka);
      wait_done(cyc);
      bus.key_in    = kb;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      checks++;
      if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept got kv=%b busy=%b exp 0 1", bus.keys_valid, bus.busy);
      end
      wait_done(cyc);
      checks++;
      if (cyc != 10) begin
         failures++;
         $display("FAIL b2b_done_latency got %0d exp 10", cyc);
      end
      model_expand(kb);
      read_rk(4'd10, d);
      checks++;
      if (d !== exp_rk[10]) begin
         failures++;
         $display("FAIL b2b_rk10 got %h exp %h", d, exp_rk[10]);
      end
   endtask

   task automatic test_hold_valid();
      logic [127:0] k, d;
      int cnt, dones;
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      bus.key_in    = k;
      bus.key_valid = 1'b1;
      @(negedge clk);
      bus.key_in = ~k;
      cnt = 0; dones = 0;
      while (!bus.key_ready && cnt < 20) begin
         cnt++;
         if (bus.done) dones++;
         @(negedge clk);
      end
      if (bus.done) dones++;
      bus.key_valid = 1'b0;
      checks++;
      if (cnt != 10 || dones != 1) begin
         failures++;
         $display("FAIL hold_ready_low got %0d cycles %0d dones exp 10 1", cnt, dones);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL hold_no_extra_accept got busy=%b exp 0", bus.busy);
      end
      model_expand(k);
      read_rk(4'd10, d);
      checks++;
      if (d !== exp_rk[10]) begin
         failures++;
         $display("FAIL hold_rk10 got %h exp %h", d, exp_rk[10]);
      end
   endtask

   task automatic test_abort();
      logic [127:0] d;
      start_key({$urandom, $urandom, $urandom, $urandom});
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.key_ready, bus.busy, bus.done, bus.keys_valid} !== 4'b1000 ||
          bus.rk_data !== 128'h0) begin
         failures++;
         $display("FAIL abort_async got flags=%b rk_data=%h exp 1000 0",
                  {bus.key_ready, bus.busy, bus.done, bus.keys_valid}, bus.rk_data);
      end
      @(negedge clk);
      rst = 1'b0;
      read_rk(4'd3, d);
      checks++;
      if (d !== 128'h0) begin
         failures++;
         $display("FAIL abort_rk3 got %h exp 0", d);
      end
      read_rk(4'd0, d);
      checks++;
      if (d !== 128'h0) begin
         failures++;
         $display("FAIL abort_rk0 got %h exp 0", d);
      end
      test_expand("post_abort", {$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic test_addr_range();
      logic [127:0] d;
      for (int a = 11; a <= 15; a++) begin
         read_rk(4'(a), d);
         checks++;
         if (d !== 128'h0) begin
            failures++;
            $display("FAIL oob_addr%0d got %h exp 0", a, d);
         end
      end
`ifdef AES_KEYEXP_LAST_KEY_EN
      checks++;
      if (bus.last_key !== exp_rk[10]) begin
         failures++;
         $display("FAIL last_key got %h exp %h", bus.last_key, exp_rk[10]);
      end
`endif
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_known_vectors();
      test_random();
      test_back_to_back();
      test_hold_valid();
      test_abort();
      test_addr_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
